// File: rtl/memory_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-ported RAM.
// Optional round-robin fairness between ports: define MEMORY_ARBITER_FAIRNESS_EN.
module memory_arbiter #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIServ, StDServ, StRecover} state_e;

  state_e state_q, state_d;
  logic   d_req;
  logic   pick_i;

  assign d_req = dREN | dWEN;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  logic fair_q, fair_d;
  // Instruction wins a tie only when the previous data completion starved it.
  assign pick_i = iREN & (~d_req | fair_q);
`else
  assign pick_i = iREN & ~d_req;
`endif

  always_comb begin
    state_d  = state_q;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
    fair_d   = fair_q;
`endif
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_i) begin
          state_d = StIServ;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
          fair_d  = 1'b0;
`endif
        end else if (d_req) begin
          state_d = StDServ;
        end
      end
      StIServ: begin
        if (!iREN) begin
          state_d = StIdle;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RamAccess) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = StIdle;
          end else if (ramstate == RamError) begin
            state_d = StRecover;
          end
        end
      end
      StDServ: begin
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RamAccess) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = StIdle;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
            if (iREN) fair_d = 1'b1;
`endif
          end else if (ramstate == RamError) begin
            state_d = StRecover;
          end
        end
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
      fair_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
      fair_q  <= fair_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; RAM responses are driven by hand.
module tb_memory_arbiter;

  localparam int unsigned W = 32;
  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

  logic         CLK = 1'b0, nRST;
  logic         iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0]   ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".ren"}, {31'd0, ramREN}, 32'd0);
    check_eq({tag, ".wen"}, {31'd0, ramWEN}, 32'd0);
    check_eq({tag, ".iwait"}, {31'd0, iwait}, 32'd1);
    check_eq({tag, ".dwait"}, {31'd0, dwait}, 32'd1);
  endtask

  logic [1:0] exp_done [8];

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = Free;
    tick(); tick();
    @(negedge CLK);
    check_idle("rst");
    check_eq("rst.addr", ramaddr, 32'h0);
    check_eq("rst.iload", iload, 32'h0);
    tick();
    nRST = 1'b1;

    // Single fetch, zero-wait RAM
    tick();
    iREN = 1; iaddr = 32'h40; ramstate = Access; ramload = 32'h8C010004;
    @(negedge CLK);
    check_idle("fetch.idle");
    tick();
    @(negedge CLK);
    check_eq("fetch.addr", ramaddr, 32'h40);
    check_eq("fetch.ren", {31'd0, ramREN}, 32'd1);
    check_eq("fetch.iwait", {31'd0, iwait}, 32'd0);
    check_eq("fetch.iload", iload, 32'h8C010004);
    check_eq("fetch.dwait", {31'd0, dwait}, 32'd1);
    tick();
    iREN = 0;
    @(negedge CLK);
    check_idle("fetch.after");
    check_eq("fetch.iload0", iload, 32'h0);

    // Conflict: data write beats fetch, one idle cycle between grants
    tick();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ramstate = Access; ramload = 32'h11;
    tick();
    @(negedge CLK);
    check_eq("conf.wen", {31'd0, ramWEN}, 32'd1);
    check_eq("conf.ren", {31'd0, ramREN}, 32'd0);
    check_eq("conf.addr", ramaddr, 32'h100);
    check_eq("conf.store", ramstore, 32'hDEADBEEF);
    check_eq("conf.dwait", {31'd0, dwait}, 32'd0);
    check_eq("conf.iwait", {31'd0, iwait}, 32'd1);
    tick();
    dWEN = 0;
    @(negedge CLK);
    check_idle("conf.gap");
    tick();
    @(negedge CLK);
    check_eq("conf.iaddr", ramaddr, 32'h44);
    check_eq("conf.iwait", {31'd0, iwait}, 32'd0);
    check_eq("conf.iload", iload, 32'h11);
    tick();
    iREN = 0;

    // Reset mid-DSERV
    dREN = 1; daddr = 32'h200; ramstate = Busy;
    tick();
    @(negedge CLK);
    check_eq("mrst.ren", {31'd0, ramREN}, 32'd1);
    check_eq("mrst.addr", ramaddr, 32'h200);
    #1 nRST = 1'b0;
    #1;
    check_idle("mrst.now");
    check_eq("mrst.addr0", ramaddr, 32'h0);
    tick();
    nRST = 1'b1; dREN = 0;
    @(negedge CLK);
    check_idle("mrst.after");

    // Fairness: both ports request continuously
    tick();
    dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h80; ramstate = Access; ramload = 32'h55;
    for (int k = 0; k < 8; k++) exp_done[k] = 2'b00;
    exp_done[1] = 2'b01;
    exp_done[5] = 2'b01;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
    exp_done[3] = 2'b10;
    exp_done[7] = 2'b10;
`else
    exp_done[3] = 2'b01;
    exp_done[7] = 2'b01;
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check_eq($sformatf("fair.c%0d", k), {30'd0, ~iwait, ~dwait}, {30'd0, exp_done[k]});
      if (exp_done[k] == 2'b01) check_eq($sformatf("fair.dload%0d", k), dload, 32'h55);
      tick();
    end
    dREN = 0; iREN = 0;
    tick();

    // ERROR during a data read, recover, retry
    dREN = 1; daddr = 32'h200; ramstate = Busy;
    tick();
    ramstate = Error;
    @(negedge CLK);
    check_eq("err.ren", {31'd0, ramREN}, 32'd1);
    check_eq("err.dwait", {31'd0, dwait}, 32'd1);
    check_eq("err.dload0", dload, 32'h0);
    tick();
    ramstate = Free;
    @(negedge CLK);
    check_idle("err.recover");
    tick();
    @(negedge CLK);
    check_idle("err.idle");
    tick();
    ramstate = Access; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    check_eq("err.addr", ramaddr, 32'h200);
    check_eq("err.dwait2", {31'd0, dwait}, 32'd0);
    check_eq("err.dload", dload, 32'hCAFEF00D);
    tick();
    dREN = 0;

    // Abort after one BUSY cycle
    dREN = 1; daddr = 32'h180; ramstate = Busy;
    tick();
    @(negedge CLK);
    check_eq("abrt.ren", {31'd0, ramREN}, 32'd1);
    check_eq("abrt.dwait", {31'd0, dwait}, 32'd1);
    tick();
    dREN = 0;
    @(negedge CLK);
    check_idle("abrt.drop");
    tick();
    iREN = 1; iaddr = 32'h90; ramstate = Access; ramload = 32'h77;
    @(negedge CLK);
    check_idle("abrt.idle");
    tick();
    @(negedge CLK);
    check_eq("abrt.iwait", {31'd0, iwait}, 32'd0);
    check_eq("abrt.iload", iload, 32'h77);
    tick();
    iREN = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
